// File: rtl/my_reset_sequencer_if.sv
// Button input and reset outputs of the reset sequencer, plus its FSM state for observation.
interface my_reset_sequencer_if;
  logic       i_btn_n;
  logic       o_resetn;
  logic       o_por_done;
  logic [7:0] o_rst_count;
  logic [1:0] state;

  modport master (
    output i_btn_n,
    input  o_resetn,
    input  o_por_done,
    input  o_rst_count,
    input  state
  );

  modport slave (
    input  i_btn_n,
    output o_resetn,
    output o_por_done,
    output o_rst_count,
    output state
  );
endinterface

// File: rtl/my_reset_sequencer.sv
// Power-on hold and debounced push-button reset generator driving the design-wide o_resetn.
// No handshake: the button is a level input and the outputs are plain levels.
module my_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int POR_CYCLES      = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input logic                  i_clk,
  input logic                  rst,
  my_reset_sequencer_if.slave  bus
);

  localparam int MAX_CYCLES = (POR_CYCLES > DEBOUNCE_CYCLES) ? POR_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_chain;
  logic [SYNC_STAGES-1:0] btn_chain;
  logic                   rst_sync;
  logic                   btn_sync;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             por_done_q,  por_done_d;
  logic [7:0]       rst_count_q, rst_count_d;
  logic             resetn_q,    resetn_d;

  // Chains clear to 0 on rst, so the release edge of rst is resynchronised to i_clk.
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      rst_chain <= '0;
      btn_chain <= '0;
    end else begin
      rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
      btn_chain <= {btn_chain[SYNC_STAGES-2:0], bus.i_btn_n};
    end
  end

  assign rst_sync = rst_chain[SYNC_STAGES-1];
  assign btn_sync = btn_chain[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      por_done_q  <= 1'b0;
      rst_count_q <= 8'd0;
      resetn_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      por_done_q  <= por_done_d;
      rst_count_q <= rst_count_d;
      resetn_q    <= resetn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    por_done_d  = por_done_q;
    rst_count_d = rst_count_q;
    case (state_q)
      HOLD: begin
        if (!rst_sync) begin
          cnt_d = '0;
        end else if (cnt_q == POR_LAST) begin
          state_d    = RUN;
          cnt_d      = '0;
          por_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!btn_sync) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        if (btn_sync) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          if (rst_count_q != 8'hFF) rst_count_d = rst_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!btn_sync) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoded from the next state and then registered, so o_resetn changes on the same edge as the state.
  always_comb begin
    resetn_d = 1'b0;
    if (state_d == RUN || state_d == PRESS) resetn_d = 1'b1;
  end

  assign bus.o_resetn    = resetn_q;
  assign bus.o_por_done  = por_done_q;
  assign bus.o_rst_count = rst_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_my_reset_sequencer.sv
// Directed bench: power-up, glitch rejection, press/release, bounce, rst abort, count saturation.
module tb_my_reset_sequencer;

  logic i_clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  my_reset_sequencer_if bus ();
  my_reset_sequencer_if bus2 ();

  my_reset_sequencer #(
    .SYNC_STAGES    (2),
    .POR_CYCLES     (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .i_clk(i_clk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  my_reset_sequencer #(
    .SYNC_STAGES    (2),
    .POR_CYCLES     (1),
    .DEBOUNCE_CYCLES(1)
  ) dut_sat (
    .i_clk(i_clk),
    .rst  (rst2),
    .bus  (bus2.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b0;
    rst2         = 1'b0;
    bus.i_btn_n  = 1'b1;
    bus2.i_btn_n = 1'b1;

    // reset state
    tick(2);
    check("rst_resetn", bus.o_resetn, 8'd0);
    check("rst_por_done", bus.o_por_done, 8'd0);
    check("rst_count", bus.o_rst_count, 8'd0);
    check("rst_state", bus.state, 8'd0);

    // power-up: rises after edge 18
    rst = 1'b1;
    tick(17);
    check("pu17_resetn", bus.o_resetn, 8'd0);
    check("pu17_por_done", bus.o_por_done, 8'd0);
    tick(1);
    check("pu18_resetn", bus.o_resetn, 8'd1);
    check("pu18_por_done", bus.o_por_done, 8'd1);
    check("pu18_count", bus.o_rst_count, 8'd0);
    check("pu18_state", bus.state, 8'd1);

    // 5-cycle low pulse is rejected
    bus.i_btn_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("glitch_lo_resetn", bus.o_resetn, 8'd1);
    end
    bus.i_btn_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_hi_resetn", bus.o_resetn, 8'd1);
    end
    check("glitch_count", bus.o_rst_count, 8'd0);
    check("glitch_state", bus.state, 8'd1);

    // held press: falls after edge 11, release rises after edge 26
    bus.i_btn_n = 1'b0;
    tick(10);
    check("press10_resetn", bus.o_resetn, 8'd1);
    check("press10_count", bus.o_rst_count, 8'd0);
    tick(1);
    check("press11_resetn", bus.o_resetn, 8'd0);
    check("press11_count", bus.o_rst_count, 8'd1);
    check("press11_state", bus.state, 8'd3);
    tick(19);
    bus.i_btn_n = 1'b1;
    tick(25);
    check("rel25_resetn", bus.o_resetn, 8'd0);
    check("rel25_por_done", bus.o_por_done, 8'd1);
    tick(1);
    check("rel26_resetn", bus.o_resetn, 8'd1);
    check("rel26_por_done", bus.o_por_done, 8'd1);
    check("rel26_count", bus.o_rst_count, 8'd1);

    // bounce during release restarts the debounce
    bus.i_btn_n = 1'b0;
    tick(11);
    check("bounce_press_resetn", bus.o_resetn, 8'd0);
    check("bounce_press_count", bus.o_rst_count, 8'd2);
    tick(3);
    bus.i_btn_n = 1'b1;
    tick(4);
    bus.i_btn_n = 1'b0;
    tick(1);
    bus.i_btn_n = 1'b1;
    tick(25);
    check("bounce25_resetn", bus.o_resetn, 8'd0);
    tick(1);
    check("bounce26_resetn", bus.o_resetn, 8'd1);
    check("bounce26_count", bus.o_rst_count, 8'd2);

    // rst asserted mid-PRESS
    bus.i_btn_n = 1'b0;
    tick(7);
    check("midpress_state", bus.state, 8'd2);
    check("midpress_resetn", bus.o_resetn, 8'd1);
    rst = 1'b0;
    #1;
    check("abort_resetn", bus.o_resetn, 8'd0);
    check("abort_por_done", bus.o_por_done, 8'd0);
    check("abort_count", bus.o_rst_count, 8'd0);
    check("abort_state", bus.state, 8'd0);
    bus.i_btn_n = 1'b1;
    #1;
    rst = 1'b1;
    tick(17);
    check("repu17_resetn", bus.o_resetn, 8'd0);
    check("repu17_por_done", bus.o_por_done, 8'd0);
    tick(1);
    check("repu18_resetn", bus.o_resetn, 8'd1);
    check("repu18_por_done", bus.o_por_done, 8'd1);

    // short rst glitch between clock edges
    tick(3);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    check("rglitch_resetn", bus.o_resetn, 8'd0);
    check("rglitch_por_done", bus.o_por_done, 8'd0);
    tick(17);
    check("rglitch17_resetn", bus.o_resetn, 8'd0);
    tick(1);
    check("rglitch18_resetn", bus.o_resetn, 8'd1);

    // saturation with POR_CYCLES = DEBOUNCE_CYCLES = 1
    rst2 = 1'b1;
    tick(4);
    check("sat_pu_resetn", bus2.o_resetn, 8'd1);
    for (int i = 1; i <= 260; i++) begin
      bus2.i_btn_n = 1'b0;
      tick(6);
      bus2.i_btn_n = 1'b1;
      tick(6);
      if (i == 1 || i == 254 || i == 255 || i == 260)
        check("sat_count", bus2.o_rst_count, (i > 255) ? 8'd255 : 8'(i));
    end
    check("sat_resetn", bus2.o_resetn, 8'd1);
    check("sat_por_done", bus2.o_por_done, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
